// File: rtl/pcie_tx_hdr_merge.sv
// Merges a TLP header stream and a DW-packed payload stream into 128-bit AXI-S TX beats for the PCIe core.
// Optional macro PCIE_TX_STAT_EN adds tx_pkt_count, a count of transmitted TLPs.
module pcie_tx_hdr_merge (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] hdr,
  input  logic         hdr_valid,
  output logic         hdr_ready,
  input  logic [127:0] data,
  input  logic         data_valid,
  output logic         data_ready,
  output logic [127:0] s_axis_tx_tdata,
  output logic [15:0]  s_axis_tx_tstrb,
  output logic         s_axis_tx_tlast,
  output logic         s_axis_tx_tvalid,
  input  logic         s_axis_tx_tready,
  output logic [3:0]   s_axis_tx_tuser
`ifdef PCIE_TX_STAT_EN
  ,
  output logic [31:0]  tx_pkt_count
`endif
);

  localparam int unsigned DW_W  = 11;
  localparam int unsigned CNT_W = 9;

  typedef enum logic [1:0] {IDLE, HDR, DATA, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [127:0]       hdr_q;
  logic               fmt4_q, has_data_q;
  logic [CNT_W-1:0]   beats_q, words_q;
  logic [15:0]        last_strb_q;
  logic [95:0]        residual_q;
  logic               rst_done;

  logic               out_free, hdr_acc, data_acc, out_load, beat_last;
  logic [127:0]       beat, beat_mask;
  logic [15:0]        beat_strb;
  logic [DW_W-1:0]    len_dw, total_dw;
  logic [CNT_W-1:0]   beats_dec, words_dec;
  logic [15:0]        strb_dec;
  state_t             after_payload;

  assign s_axis_tx_tuser = 4'b0000;
  assign out_free = !s_axis_tx_tvalid || s_axis_tx_tready;

  // Header decode, used only on the accept cycle
  always_comb begin
    len_dw    = (hdr[9:0] == 10'd0) ? DW_W'(1024) : DW_W'(hdr[9:0]);
    total_dw  = (hdr[29] ? DW_W'(4) : DW_W'(3)) + (hdr[30] ? len_dw : DW_W'(0));
    beats_dec = CNT_W'((total_dw + DW_W'(3)) >> 2);
    words_dec = hdr[30] ? CNT_W'((len_dw + DW_W'(3)) >> 2) : CNT_W'(0);
    case (total_dw[1:0])
      2'd1:    strb_dec = 16'h000F;
      2'd2:    strb_dec = 16'h00FF;
      2'd3:    strb_dec = 16'h0FFF;
      default: strb_dec = 16'hFFFF;
    endcase
  end

  // Next-state, handshakes and the beat to load into the output register
  always_comb begin
    state_nxt  = state;
    hdr_ready  = 1'b0;
    data_ready = 1'b0;
    out_load   = 1'b0;
    beat       = '0;
    after_payload = (beats_q == CNT_W'(1)) ? IDLE :
                    (words_q == CNT_W'(1)) ? FLUSH : DATA;
    case (state)
      IDLE: begin
        hdr_ready = rst_done && out_free;
        if (hdr_valid && hdr_ready) state_nxt = HDR;
      end
      HDR: begin
        if (fmt4_q) begin
          out_load = out_free;
          beat     = hdr_q;
          if (out_free) state_nxt = has_data_q ? DATA : IDLE;
        end else if (!has_data_q) begin
          out_load = out_free;
          beat     = {32'h0, hdr_q[95:0]};
          if (out_free) state_nxt = IDLE;
        end else begin
          data_ready = out_free;
          out_load   = out_free && data_valid;
          beat       = {data[31:0], hdr_q[95:0]};
          if (out_load) state_nxt = after_payload;
        end
      end
      DATA: begin
        data_ready = out_free;
        out_load   = out_free && data_valid;
        beat       = fmt4_q ? data : {data[31:0], residual_q};
        if (out_load) state_nxt = after_payload;
      end
      FLUSH: begin
        out_load = out_free;
        beat     = {32'h0, residual_q};
        if (out_free) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    hdr_acc   = hdr_valid && hdr_ready;
    data_acc  = data_valid && data_ready;
    beat_last = (beats_q == CNT_W'(1));
    beat_strb = beat_last ? last_strb_q : 16'hFFFF;
    for (int i = 0; i < 16; i++) beat_mask[i*8 +: 8] = {8{beat_strb[i]}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rst_done         <= 1'b0;
      hdr_q            <= '0;
      fmt4_q           <= 1'b0;
      has_data_q       <= 1'b0;
      beats_q          <= '0;
      words_q          <= '0;
      last_strb_q      <= '0;
      residual_q       <= '0;
      s_axis_tx_tdata  <= '0;
      s_axis_tx_tstrb  <= '0;
      s_axis_tx_tlast  <= 1'b0;
      s_axis_tx_tvalid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rst_done <= 1'b1;
      if (hdr_acc) begin
        hdr_q       <= hdr;
        fmt4_q      <= hdr[29];
        has_data_q  <= hdr[30];
        beats_q     <= beats_dec;
        words_q     <= words_dec;
        last_strb_q <= strb_dec;
      end else if (out_load) begin
        beats_q <= beats_q - CNT_W'(1);
      end
      if (data_acc) begin
        words_q    <= words_q - CNT_W'(1);
        residual_q <= data[127:32];
      end
      // Skid register: holds its beat until the core takes it
      if (out_load) begin
        s_axis_tx_tvalid <= 1'b1;
        s_axis_tx_tdata  <= beat & beat_mask;
        s_axis_tx_tstrb  <= beat_strb;
        s_axis_tx_tlast  <= beat_last;
      end else if (s_axis_tx_tready) begin
        s_axis_tx_tvalid <= 1'b0;
      end
    end
  end

`ifdef PCIE_TX_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_pkt_count <= '0;
    else if (s_axis_tx_tvalid && s_axis_tx_tready && s_axis_tx_tlast)
      tx_pkt_count <= tx_pkt_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pcie_tx_hdr_merge.sv
// Directed bench for pcie_tx_hdr_merge: header/payload merging, tstrb/tlast on the final beat,
// back-pressure hold, mid-packet reset and the 1024-DW length boundary.
module tb_pcie_tx_hdr_merge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] hdr;
  logic         hdr_valid;
  logic         hdr_ready;
  logic [127:0] data;
  logic         data_valid;
  logic         data_ready;
  logic [127:0] tdata;
  logic [15:0]  tstrb;
  logic         tlast;
  logic         tvalid;
  logic         tready;
  logic [3:0]   tuser;
`ifdef PCIE_TX_STAT_EN
  logic [31:0]  pkt_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [127:0] q_data[$];
  logic [15:0]  q_strb[$];
  logic         q_last[$];

  pcie_tx_hdr_merge dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .hdr              (hdr),
    .hdr_valid        (hdr_valid),
    .hdr_ready        (hdr_ready),
    .data             (data),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .s_axis_tx_tdata  (tdata),
    .s_axis_tx_tstrb  (tstrb),
    .s_axis_tx_tlast  (tlast),
    .s_axis_tx_tvalid (tvalid),
    .s_axis_tx_tready (tready),
    .s_axis_tx_tuser  (tuser)
`ifdef PCIE_TX_STAT_EN
    ,
    .tx_pkt_count     (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  // Records every beat that will handshake on the coming rising edge
  always @(negedge clk) begin
    #1;
    if (rst_n && tvalid && tready) begin
      q_data.push_back(tdata);
      q_strb.push_back(tstrb);
      q_last.push_back(tlast);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge
  task automatic push_hdr(input logic [127:0] h);
    int n = 0;
    bit done = 0;
    hdr = h;
    hdr_valid = 1'b1;
    while (!done && n < 200) begin
      #1;
      if (hdr_ready) done = 1;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    hdr_valid = 1'b0;
    check("hdr_accept_timeout", 128'(done), 128'(1));
  endtask

  task automatic push_data(input logic [127:0] d);
    int n = 0;
    bit done = 0;
    data = d;
    data_valid = 1'b1;
    while (!done && n < 200) begin
      #1;
      if (data_ready) done = 1;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    data_valid = 1'b0;
    check("data_accept_timeout", 128'(done), 128'(1));
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (q_data.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check("beat_count", 128'(q_data.size()), 128'(n));
  endtask

  task automatic check_beat(input string tag, input int idx,
                            input logic [127:0] d, input logic [15:0] s, input logic l);
    if (idx < q_data.size()) begin
      check({tag, "_tdata"}, q_data[idx], d);
      check({tag, "_tstrb"}, 128'(q_strb[idx]), 128'(s));
      check({tag, "_tlast"}, 128'(q_last[idx]), 128'(l));
    end else begin
      check({tag, "_missing"}, 128'(q_data.size()), 128'(idx + 1));
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_strb.delete();
    q_last.delete();
  endtask

  bit pat [12] = '{1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1};

  initial begin
    rst_n = 1'b0;
    hdr = '0;
    hdr_valid = 1'b0;
    data = '0;
    data_valid = 1'b0;
    tready = 1'b1;
    #12;
    check("rst_tvalid", 128'(tvalid), 128'(0));
    check("rst_tdata", tdata, 128'h0);
    check("rst_tstrb", 128'(tstrb), 128'(0));
    check("rst_tlast", 128'(tlast), 128'(0));
    check("rst_hdr_ready", 128'(hdr_ready), 128'(0));
    check("rst_data_ready", 128'(data_ready), 128'(0));
    check("tuser", 128'(tuser), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("hdr_ready_before_edge", 128'(hdr_ready), 128'(0));
    @(negedge clk);
    #1;
    check("hdr_ready_after_edge", 128'(hdr_ready), 128'(1));
    @(negedge clk);

    // 3DW MRd, no data
    clear_q();
    push_hdr(128'hFFFFFFFF_33333333_22222222_00000001);
    wait_beats(1);
    check_beat("mrd", 0, 128'h00000000_33333333_22222222_00000001, 16'h0FFF, 1'b1);

    // 3DW MWr len 1
    clear_q();
    push_hdr(128'h00000000_CAFE0000_12340000_40000001);
    push_data(128'h99999999_88888888_77777777_DEADBEEF);
    wait_beats(1);
    check_beat("mwr1", 0, 128'hDEADBEEF_CAFE0000_12340000_40000001, 16'hFFFF, 1'b1);

    // 3DW MWr len 4: header beat plus a flush beat of the residual
    clear_q();
    push_hdr(128'h00000000_AAAA0000_BBBB0000_40000004);
    push_data(128'h00004444_00003333_00002222_00001111);
    wait_beats(2);
    check_beat("mwr4_b0", 0, 128'h00001111_AAAA0000_BBBB0000_40000004, 16'hFFFF, 1'b0);
    check_beat("mwr4_b1", 1, 128'h00000000_00004444_00003333_00002222, 16'h0FFF, 1'b1);

    // 4DW MWr len 6
    clear_q();
    push_hdr(128'h0000000C_0000000B_0000000A_60000006);
    push_data(128'h13131313_12121212_11111111_10101010);
    push_data(128'h23232323_22222222_21212121_20202020);
    wait_beats(3);
    check_beat("mwr4dw_b0", 0, 128'h0000000C_0000000B_0000000A_60000006, 16'hFFFF, 1'b0);
    check_beat("mwr4dw_b1", 1, 128'h13131313_12121212_11111111_10101010, 16'hFFFF, 1'b0);
    check_beat("mwr4dw_b2", 2, 128'h00000000_00000000_21212121_20202020, 16'h00FF, 1'b1);

    // 4DW no-data header, then two back-to-back 3DW reads
    clear_q();
    push_hdr(128'h44444444_33333333_22222222_20000000);
    push_hdr(128'h00000000_00000011_00000010_00000001);
    push_hdr(128'h00000000_00000021_00000020_00000001);
    wait_beats(3);
    check_beat("nd4dw", 0, 128'h44444444_33333333_22222222_20000000, 16'hFFFF, 1'b1);
    check_beat("b2b_0", 1, 128'h00000000_00000011_00000010_00000001, 16'h0FFF, 1'b1);
    check_beat("b2b_1", 2, 128'h00000000_00000021_00000020_00000001, 16'h0FFF, 1'b1);

    // 3DW MWr len 8 under back-pressure
    clear_q();
    fork
      begin
        push_hdr(128'h00000000_00000055_00000066_40000008);
        push_data(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
        push_data(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
      end
      begin
        logic [127:0] held;
        bit stall;
        stall = 0;
        held = '0;
        for (int k = 0; k < 12; k++) begin
          tready = pat[k];
          #1;
          if (stall) check("stall_hold", tdata, held);
          stall = tvalid && !tready;
          held = tdata;
          @(negedge clk);
        end
        tready = 1'b1;
      end
    join
    wait_beats(3);
    check_beat("stall_b0", 0, 128'hA0A0A0A0_00000055_00000066_40000008, 16'hFFFF, 1'b0);
    check_beat("stall_b1", 1, 128'hB0B0B0B0_A3A3A3A3_A2A2A2A2_A1A1A1A1, 16'hFFFF, 1'b0);
    check_beat("stall_b2", 2, 128'h00000000_B3B3B3B3_B2B2B2B2_B1B1B1B1, 16'h0FFF, 1'b1);

    // 3DW MWr len 0 (1024 DW): 256 data words, 257 beats
    clear_q();
    push_hdr(128'h00000000_00000001_00000002_40000000);
    for (int i = 0; i < 256; i++)
      push_data({32'(4*i+3), 32'(4*i+2), 32'(4*i+1), 32'(4*i)});
    wait_beats(257);
    check_beat("len0_b0", 0, 128'h00000000_00000001_00000002_40000000, 16'hFFFF, 1'b0);
    check_beat("len0_b1", 1, 128'h00000004_00000003_00000002_00000001, 16'hFFFF, 1'b0);
    check_beat("len0_last", 256, 128'h00000000_000003FF_000003FE_000003FD, 16'h0FFF, 1'b1);

    // Reset in the DATA state of a len 16 TLP
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear_q();
    push_hdr(128'h00000000_00000077_00000088_40000010);
    push_data(128'h13000000_12000000_11000000_10000000);
    push_data(128'h23000000_22000000_21000000_20000000);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 128'(tvalid), 128'(0));
    check("midrst_tdata", tdata, 128'h0);
    check("midrst_data_ready", 128'(data_ready), 128'(0));
    check("midrst_hdr_ready", 128'(hdr_ready), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_q();
    push_hdr(128'h00000000_00000099_00000098_00000001);
    wait_beats(1);
    check_beat("postrst", 0, 128'h00000000_00000099_00000098_00000001, 16'h0FFF, 1'b1);
`ifdef PCIE_TX_STAT_EN
    check("pkt_count", 128'(pkt_count), 128'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
